meta_trend_stat_trainer: RTL and testbench

Owns and trains the statistic/trend counter tables consumed by the meta predictor. Each branch prediction is recorded in a small in-order in-flight queue, tagged with the sub-predictor indices used. When the branch resolves in EX, the queue head is popped and the SP, LHP and GHP entries it used are trained. A mispredict flushes all younger records. A combinational read port feeds the meta predictor's arbiter.

---
 rtl/meta_trend_stat_trainer.sv | 159 +++++++++++++++
 tb/tb_meta_trend_stat_trainer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/meta_trend_stat_trainer.sv
// rtl/meta_trend_stat_trainer.sv - in-flight record queue and stat/trend table trainer for the meta predictor
module meta_trend_stat_trainer #(
    parameter int JUMP_STATUS_COUNTER_WIDTH     = 2,
    parameter int STAT_COUNTER_WIDTH            = 5,
    parameter int STAT_COUNTER_CLEAR_SHIFT_BITS = STAT_COUNTER_WIDTH / 2,
    parameter int SP_STAT_COUNTER_INIT_VALUE    = 1 << STAT_COUNTER_CLEAR_SHIFT_BITS,
    parameter int DEPTH                         = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    record_en,
    input  logic [2:0]                              record_type,
    input  logic                                    record_sp,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0]    record_lhp,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0]    record_ghp,
    input  logic                                    resolve_en,
    input  logic                                    resolve_taken,
    input  logic                                    resolve_mispredict,
    input  logic [2:0]                              rd_type,
    input  logic                                    rd_sp,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0]    rd_lhp,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0]    rd_ghp,
    output logic [STAT_COUNTER_WIDTH+2:0]           rd_sp_entry,
    output logic [STAT_COUNTER_WIDTH+2:0]           rd_lhp_entry,
    output logic [STAT_COUNTER_WIDTH+2:0]           rd_ghp_entry,
    output logic [$clog2(DEPTH):0]                  occupancy,
    output logic                                    full,
    output logic                                    empty,
    output logic                                    record_overflow,
    output logic                                    resolve_underflow
);
    localparam int JW = JUMP_STATUS_COUNTER_WIDTH;
    localparam int W  = STAT_COUNTER_WIDTH;
    localparam int N  = 1 << JW;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [W-1:0]  STAT_MAX = {W{1'b1}};
    localparam logic [W-1:0]  SP_INIT  = W'(SP_STAT_COUNTER_INIT_VALUE);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0] sp_stat   [0:5][0:1];
    logic [2:0]   sp_trend  [0:5][0:1];
    logic [W-1:0] lhp_stat  [0:5][0:N-1];
    logic [2:0]   lhp_trend [0:5][0:N-1];
    logic [W-1:0] ghp_stat  [0:5][0:N-1];
    logic [2:0]   ghp_trend [0:5][0:N-1];

    logic [2:0]    q_type [0:DEPTH-1];
    logic          q_sp   [0:DEPTH-1];
    logic [JW-1:0] q_lhp  [0:DEPTH-1];
    logic [JW-1:0] q_ghp  [0:DEPTH-1];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    logic          pop, flush, push, legal;
    logic [2:0]    h_type;
    logic          h_sp;
    logic [JW-1:0] h_lhp, h_ghp;
    logic          sp_ok, lhp_ok, ghp_ok, age;
    logic          rd_ok;

    // Saturating stat step; aging shift is applied before the step
    function automatic logic [W-1:0] stat_next(input logic [W-1:0] s, input logic ok, input logic ag);
        logic [W-1:0] b;
        b = ag ? (s >> STAT_COUNTER_CLEAR_SHIFT_BITS) : s;
        if (ok)
            return (b == STAT_MAX) ? b : b + W'(1);
        else
            return (b == '0) ? b : b - W'(1);
    endfunction

    // Trend is 3-bit two's complement: +1 up to +3, -2 down to -4
    function automatic logic [2:0] trend_next(input logic [2:0] t, input logic ok);
        if (ok)
            return (t == 3'b011) ? t : t + 3'd1;
        else
            return (t == 3'b100 || t == 3'b101) ? 3'b100 : t - 3'd2;
    endfunction

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign occupancy = count;
    assign legal  = (record_type <= 3'd5);
    assign pop    = resolve_en && !empty;
    assign flush  = pop && resolve_mispredict;
    assign push   = record_en && legal && (!full || pop) && !flush;

    assign h_type = q_type[head];
    assign h_sp   = q_sp[head];
    assign h_lhp  = q_lhp[head];
    assign h_ghp  = q_ghp[head];
    assign sp_ok  = (h_sp == resolve_taken);
    assign lhp_ok = (h_lhp[JW-1] == resolve_taken);
    assign ghp_ok = (h_ghp[JW-1] == resolve_taken);
    assign age    = (sp_ok  && sp_stat[h_type][h_sp]   == STAT_MAX) ||
                    (lhp_ok && lhp_stat[h_type][h_lhp] == STAT_MAX) ||
                    (ghp_ok && ghp_stat[h_type][h_ghp] == STAT_MAX);

    // Combinational read port; unused type codes read as zero
    assign rd_ok        = (rd_type <= 3'd5);
    assign rd_sp_entry  = rd_ok ? {sp_trend[rd_type][rd_sp],   sp_stat[rd_type][rd_sp]}   : '0;
    assign rd_lhp_entry = rd_ok ? {lhp_trend[rd_type][rd_lhp], lhp_stat[rd_type][rd_lhp]} : '0;
    assign rd_ghp_entry = rd_ok ? {ghp_trend[rd_type][rd_ghp], ghp_stat[rd_type][rd_ghp]} : '0;

    // Record queue: push at tail, pop at head, mispredict flushes everything younger
    always_ff @(posedge clk) begin
        if (rst) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            record_overflow   <= 1'b0;
            resolve_underflow <= 1'b0;
        end else begin
            record_overflow   <= record_en && !flush && (!legal || (full && !pop));
            resolve_underflow <= resolve_en && empty;
            if (push) begin
                q_type[tail] <= record_type;
                q_sp[tail]   <= record_sp;
                q_lhp[tail]  <= record_lhp;
                q_ghp[tail]  <= record_ghp;
            end
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end
        end
    end

    // Train the three entries selected by the popped head record
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 2; j++) begin
                    sp_stat[i][j]  <= SP_INIT;
                    sp_trend[i][j] <= 3'd0;
                end
                for (int j = 0; j < N; j++) begin
                    lhp_stat[i][j]  <= '0;
                    lhp_trend[i][j] <= 3'd0;
                    ghp_stat[i][j]  <= '0;
                    ghp_trend[i][j] <= 3'd0;
                end
            end
        end else if (pop) begin
            sp_stat[h_type][h_sp]    <= stat_next(sp_stat[h_type][h_sp], sp_ok, age);
            sp_trend[h_type][h_sp]   <= trend_next(sp_trend[h_type][h_sp], sp_ok);
            lhp_stat[h_type][h_lhp]  <= stat_next(lhp_stat[h_type][h_lhp], lhp_ok, age);
            lhp_trend[h_type][h_lhp] <= trend_next(lhp_trend[h_type][h_lhp], lhp_ok);
            ghp_stat[h_type][h_ghp]  <= stat_next(ghp_stat[h_type][h_ghp], ghp_ok, age);
            ghp_trend[h_type][h_ghp] <= trend_next(ghp_trend[h_type][h_ghp], ghp_ok);
        end
    end
endmodule

// File: tb/tb_meta_trend_stat_trainer.sv
// tb/tb_meta_trend_stat_trainer.sv - directed self-checking bench for meta_trend_stat_trainer
module tb_meta_trend_stat_trainer;
    logic       clk = 1'b0;
    logic       rst;
    logic       record_en;
    logic [2:0] record_type;
    logic       record_sp;
    logic [1:0] record_lhp, record_ghp;
    logic       resolve_en, resolve_taken, resolve_mispredict;
    logic [2:0] rd_type;
    logic       rd_sp;
    logic [1:0] rd_lhp, rd_ghp;
    logic [7:0] rd_sp_entry, rd_lhp_entry, rd_ghp_entry;
    logic [2:0] occupancy;
    logic       full, empty, record_overflow, resolve_underflow;

    int errors = 0;
    int checks = 0;

    meta_trend_stat_trainer dut (
        .clk(clk), .rst(rst),
        .record_en(record_en), .record_type(record_type), .record_sp(record_sp),
        .record_lhp(record_lhp), .record_ghp(record_ghp),
        .resolve_en(resolve_en), .resolve_taken(resolve_taken), .resolve_mispredict(resolve_mispredict),
        .rd_type(rd_type), .rd_sp(rd_sp), .rd_lhp(rd_lhp), .rd_ghp(rd_ghp),
        .rd_sp_entry(rd_sp_entry), .rd_lhp_entry(rd_lhp_entry), .rd_ghp_entry(rd_ghp_entry),
        .occupancy(occupancy), .full(full), .empty(empty),
        .record_overflow(record_overflow), .resolve_underflow(resolve_underflow)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_record(input logic [2:0] t, input logic s, input logic [1:0] l, input logic [1:0] g);
        record_en = 1'b1; record_type = t; record_sp = s; record_lhp = l; record_ghp = g;
    endtask

    task automatic do_record(input logic [2:0] t, input logic s, input logic [1:0] l, input logic [1:0] g);
        set_record(t, s, l, g);
        step();
        record_en = 1'b0;
    endtask

    task automatic do_resolve(input logic tk, input logic mp);
        resolve_en = 1'b1; resolve_taken = tk; resolve_mispredict = mp;
        step();
        resolve_en = 1'b0; resolve_mispredict = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] t, input logic s, input logic [1:0] l,
                            input logic [1:0] g, input logic [7:0] es, input logic [7:0] el, input logic [7:0] eg);
        rd_type = t; rd_sp = s; rd_lhp = l; rd_ghp = g;
        #1;
        check({tag, "_sp"},  {24'd0, rd_sp_entry},  {24'd0, es});
        check({tag, "_lhp"}, {24'd0, rd_lhp_entry}, {24'd0, el});
        check({tag, "_ghp"}, {24'd0, rd_ghp_entry}, {24'd0, eg});
    endtask

    initial begin
        rst = 1'b1; record_en = 1'b0; record_type = '0; record_sp = 1'b0; record_lhp = '0; record_ghp = '0;
        resolve_en = 1'b0; resolve_taken = 1'b0; resolve_mispredict = 1'b0;
        rd_type = '0; rd_sp = 1'b0; rd_lhp = '0; rd_ghp = '0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_occ", {29'd0, occupancy}, 32'd0);
        check("rst_ovf", {31'd0, record_overflow}, 32'd0);
        check("rst_unf", {31'd0, resolve_underflow}, 32'd0);
        for (int t = 0; t < 6; t++)
            for (int i = 0; i < 4; i++)
                rd_check("rst_tab", 3'(t), i[0], 2'(i), 2'(i), 8'h04, 8'h00, 8'h00);

        // Basic training on beq
        do_record(3'd5, 1'b1, 2'b11, 2'b01);
        check("rec1_occ", {29'd0, occupancy}, 32'd1);
        check("rec1_empty", {31'd0, empty}, 32'd0);
        do_resolve(1'b1, 1'b0);
        rd_check("beq_train", 3'd5, 1'b1, 2'b11, 2'b01, 8'h25, 8'h21, 8'hC0);
        check("beq_empty", {31'd0, empty}, 32'd1);

        // Saturation then aging on bne
        for (int i = 0; i < 27; i++) begin
            do_record(3'd4, 1'b0, 2'b00, 2'b00);
            do_resolve(1'b0, 1'b0);
        end
        rd_check("bne_sat", 3'd4, 1'b0, 2'b00, 2'b00, 8'h7F, 8'h7B, 8'h7B);
        do_record(3'd4, 1'b0, 2'b00, 2'b00);
        do_resolve(1'b0, 1'b0);
        rd_check("bne_age", 3'd4, 1'b0, 2'b00, 2'b00, 8'h68, 8'h67, 8'h67);

        // Illegal type is dropped
        do_record(3'd6, 1'b1, 2'b10, 2'b10);
        check("illegal_ovf", {31'd0, record_overflow}, 32'd1);
        check("illegal_occ", {29'd0, occupancy}, 32'd0);

        // Fill, overflow, then simultaneous record+resolve on full queue
        for (int i = 0; i < 4; i++) do_record(3'd0, 1'b1, 2'b10, 2'b10);
        check("fill_occ", {29'd0, occupancy}, 32'd4);
        check("fill_full", {31'd0, full}, 32'd1);
        do_record(3'd0, 1'b1, 2'b10, 2'b10);
        check("ovf_pulse", {31'd0, record_overflow}, 32'd1);
        check("ovf_occ", {29'd0, occupancy}, 32'd4);
        step();
        check("ovf_pulse_end", {31'd0, record_overflow}, 32'd0);
        set_record(3'd0, 1'b1, 2'b10, 2'b10);
        do_resolve(1'b1, 1'b0);
        record_en = 1'b0;
        check("rr_occ", {29'd0, occupancy}, 32'd4);
        check("rr_ovf", {31'd0, record_overflow}, 32'd0);
        rd_check("rr_train", 3'd0, 1'b1, 2'b10, 2'b10, 8'h25, 8'h21, 8'h21);
        for (int i = 0; i < 4; i++) do_resolve(1'b1, 1'b0);
        rd_check("drain_train", 3'd0, 1'b1, 2'b10, 2'b10, 8'h69, 8'h65, 8'h65);
        check("drain_empty", {31'd0, empty}, 32'd1);

        // Mispredict flush with a same-cycle record
        for (int i = 0; i < 3; i++) do_record(3'd3, 1'b0, 2'b00, 2'b00);
        check("mp_pre_occ", {29'd0, occupancy}, 32'd3);
        set_record(3'd3, 1'b0, 2'b00, 2'b00);
        do_resolve(1'b1, 1'b1);
        record_en = 1'b0;
        check("mp_occ", {29'd0, occupancy}, 32'd0);
        check("mp_empty", {31'd0, empty}, 32'd1);
        check("mp_ovf", {31'd0, record_overflow}, 32'd0);
        rd_check("mp_train", 3'd3, 1'b0, 2'b00, 2'b00, 8'hC3, 8'hC0, 8'hC0);

        // Underflow leaves tables alone
        do_resolve(1'b1, 1'b1);
        check("unf_pulse", {31'd0, resolve_underflow}, 32'd1);
        rd_check("unf_tab", 3'd3, 1'b0, 2'b00, 2'b00, 8'hC3, 8'hC0, 8'hC0);
        step();
        check("unf_pulse_end", {31'd0, resolve_underflow}, 32'd0);

        // Record plus resolve on empty queue: underflow, record still pushed
        set_record(3'd2, 1'b1, 2'b01, 2'b11);
        do_resolve(1'b0, 1'b0);
        record_en = 1'b0;
        check("er_unf", {31'd0, resolve_underflow}, 32'd1);
        check("er_occ", {29'd0, occupancy}, 32'd1);
        do_resolve(1'b0, 1'b0);
        rd_check("er_train", 3'd2, 1'b1, 2'b01, 2'b11, 8'hC3, 8'h21, 8'hC0);

        // Mid-stream reset, with record and resolve asserted
        do_record(3'd1, 1'b0, 2'b00, 2'b00);
        rst = 1'b1;
        set_record(3'd1, 1'b0, 2'b00, 2'b00);
        resolve_en = 1'b1; resolve_taken = 1'b0;
        step();
        rst = 1'b0; record_en = 1'b0; resolve_en = 1'b0;
        check("mrst_occ", {29'd0, occupancy}, 32'd0);
        check("mrst_empty", {31'd0, empty}, 32'd1);
        check("mrst_unf", {31'd0, resolve_underflow}, 32'd0);
        rd_check("mrst_t5", 3'd5, 1'b1, 2'b11, 2'b01, 8'h04, 8'h00, 8'h00);
        rd_check("mrst_t4", 3'd4, 1'b0, 2'b00, 2'b00, 8'h04, 8'h00, 8'h00);
        rd_check("mrst_t0", 3'd0, 1'b1, 2'b10, 2'b10, 8'h04, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
